// File: rtl/key_event_unit_if.sv
// CPU-side view of the key event unit: key levels, event request/acknowledge
// handshake, interrupt enable and the sticky overrun flag.
interface key_event_if;
  logic [7:0] keys;
  logic       ie;
  logic       irq;
  logic       irq_ack;
  logic [2:0] irq_key;
  logic       overrun;
  logic       ovr_clr;

  modport master (
    output ie, irq_ack, ovr_clr,
    input  keys, irq, irq_key, overrun
  );

  modport slave (
    input  ie, irq_ack, ovr_clr,
    output keys, irq, irq_key, overrun
  );
endinterface

// File: rtl/key_event_unit.sv
// Front-panel key input stage: synchronizes and debounces six buttons, turns
// presses and auto-repeats into queued per-key events presented as an irq.
module key_event_unit #(
  parameter int         DB_TICKS  = 4,
  parameter int         REP_DELAY = 32,
  parameter int         REP_RATE  = 8,
  parameter logic [7:0] REP_MASK  = 8'b1001_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [3:0]   btn,
  input  logic         Abtn,
  input  logic         Bbtn,
  key_event_if.slave   cpu
);

  localparam logic [3:0] DB_LAST   = 4'(DB_TICKS - 1);
  localparam logic [7:0] DELAY_LD  = 8'(REP_DELAY);
  localparam logic [7:0] RATE_LD   = 8'(REP_RATE);
  localparam logic [7:2] MASK_BITS = REP_MASK[7:2];

  function automatic logic [2:0] top_index(input logic [7:2] v);
    top_index = 3'd0;
    for (int k = 2; k <= 7; k++)
      if (v[k]) top_index = 3'(k);
  endfunction

  function automatic logic [7:2] key_bit(input logic [2:0] idx);
    key_bit = '0;
    for (int k = 2; k <= 7; k++)
      if (idx == 3'(k)) key_bit[k] = 1'b1;
  endfunction

  logic [5:0] raw;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [7:2] sample;

  logic [7:2] stable;
  logic [3:0] cnt [7:2];
  logic [7:2] accept;
  logic [7:2] press;
  logic [7:2] rel;

  logic       rep_act;
  logic [2:0] rep_key;
  logic [7:0] rep_cnt;
  logic [7:2] mask_press;
  logic       rep_fire;
  logic [7:2] rep_evt;

  logic [7:2] pending;
  logic [7:2] evt;
  logic [7:2] ack;
  logic [7:2] kept;
  logic [7:2] lost;
  logic       irq_int;
  logic [2:0] irq_key_int;

  assign raw = {btn, Abtn, Bbtn};

  // Raw buttons are active-low; the synchronizers idle at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sample = ~sync2;

  always_comb begin
    accept = '0;
    for (int k = 2; k <= 7; k++)
      accept[k] = tick && (sample[k] != stable[k]) && (cnt[k] == DB_LAST);
  end

  assign press = accept & sample;
  assign rel   = accept & ~sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int k = 2; k <= 7; k++)
        cnt[k] <= 4'd0;
    end else if (tick) begin
      for (int k = 2; k <= 7; k++) begin
        if (sample[k] == stable[k]) begin
          cnt[k] <= 4'd0;
        end else if (accept[k]) begin
          stable[k] <= sample[k];
          cnt[k]    <= 4'd0;
        end else begin
          cnt[k] <= cnt[k] + 4'd1;
        end
      end
    end
  end

  // A fresh press on a repeat-capable key preempts the running repeat, so the
  // old key must not also fire on that tick.
  assign mask_press = press & MASK_BITS;
  assign rep_fire   = tick && rep_act && !(|mask_press)
                      && !(|(rel & key_bit(rep_key))) && (rep_cnt == 8'd1);
  assign rep_evt    = rep_fire ? key_bit(rep_key) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_act <= 1'b0;
      rep_key <= 3'd0;
      rep_cnt <= 8'd0;
    end else if (tick) begin
      if (|mask_press) begin
        rep_act <= 1'b1;
        rep_key <= top_index(mask_press);
        rep_cnt <= DELAY_LD;
      end else if (rep_act) begin
        if (|(rel & key_bit(rep_key)))
          rep_act <= 1'b0;
        else if (rep_cnt == 8'd1)
          rep_cnt <= RATE_LD;
        else
          rep_cnt <= rep_cnt - 8'd1;
      end
    end
  end

  assign evt         = press | rep_evt;
  assign irq_int     = cpu.ie && (|pending);
  assign irq_key_int = top_index(pending);
  assign ack         = (cpu.irq_ack && irq_int) ? key_bit(irq_key_int) : '0;
  assign kept        = pending & ~ack;
  assign lost        = evt & kept;

  // An acknowledge frees its slot before new events land, so an event on the
  // key being acknowledged re-arms it instead of counting as lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      cpu.overrun <= 1'b0;
    end else begin
      pending <= kept | evt;
      if (|lost)
        cpu.overrun <= 1'b1;
      else if (cpu.ovr_clr)
        cpu.overrun <= 1'b0;
    end
  end

  assign cpu.keys    = {stable, 2'b00};
  assign cpu.irq     = irq_int;
  assign cpu.irq_key = irq_key_int;

endmodule

// File: tb/tb_key_event_unit.sv
// Self-checking bench for key_event_unit: a tick-level behavioural model is
// compared every cycle, with directed scenarios and literal expectations.
module tb_key_event_unit;

  localparam int         DB    = 4;
  localparam int         DELAY = 32;
  localparam int         RATE  = 8;
  localparam logic [7:0] MASK  = 8'b1001_0000;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] btn;
  logic       Abtn;
  logic       Bbtn;

  key_event_if bus();

  key_event_unit #(
    .DB_TICKS(DB), .REP_DELAY(DELAY), .REP_RATE(RATE), .REP_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .Abtn(Abtn), .Bbtn(Bbtn), .cpu(bus)
  );

  int errors = 0;
  int checks = 0;
  int tcount = 0;
  int phase  = 0;
  bit checking = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  always @(posedge clk)
    if (!rst && tick) tcount++;

  // Behavioural model: per-key differing-sample streaks, repeat timing from
  // elapsed ticks since the press, pending as a plain bit set.
  logic [5:0] m_s1, m_s2;
  bit   [7:2] m_stable, m_pend, m_samp, m_ev;
  int         m_streak [8];
  bit         m_ovr, m_newov, m_rep_on;
  int         m_rep_key, m_rep_start, m_ticks, m_el;
  int         m_press_cnt [8];
  int         m_rep_log [$];

  function automatic int topIdx(input bit [7:2] v);
    for (int k = 7; k >= 2; k--)
      if (v[k]) return k;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_stable = 0; m_pend = 0; m_ovr = 0;
      m_rep_on = 0; m_ticks = 0;
      for (int k = 0; k < 8; k++) m_streak[k] = 0;
    end else begin
      m_samp = ~m_s2;
      m_s2 = m_s1;
      m_s1 = {btn, Abtn, Bbtn};
      m_ev = 0;
      m_newov = 0;
      if (bus.irq_ack && bus.ie && m_pend != 0) m_pend[topIdx(m_pend)] = 0;
      if (tick) begin
        m_ticks++;
        for (int k = 2; k <= 7; k++) begin
          if (m_samp[k] != m_stable[k]) m_streak[k]++; else m_streak[k] = 0;
          if (m_streak[k] == DB) begin
            m_streak[k] = 0;
            m_stable[k] = m_samp[k];
            if (m_samp[k]) begin
              m_ev[k] = 1;
              m_press_cnt[k]++;
              if (MASK[k]) begin
                m_rep_on = 1; m_rep_key = k; m_rep_start = m_ticks;
              end
            end else if (m_rep_on && m_rep_key == k) begin
              m_rep_on = 0;
            end
          end
        end
        if (m_rep_on) begin
          m_el = m_ticks - m_rep_start;
          if (m_el >= DELAY && (m_el - DELAY) % RATE == 0) begin
            m_ev[m_rep_key] = 1;
            m_rep_log.push_back(m_el);
          end
        end
      end
      for (int k = 2; k <= 7; k++)
        if (m_ev[k]) begin
          if (m_pend[k]) m_newov = 1; else m_pend[k] = 1;
        end
      if (m_newov) m_ovr = 1;
      else if (bus.ovr_clr) m_ovr = 0;
    end
  end

  always @(negedge clk)
    if (checking) begin
      checkOutput("model_keys", bus.keys, {m_stable, 2'b00});
      checkOutput("model_irq", {7'd0, bus.irq}, {7'd0, bus.ie & (m_pend != 0)});
      checkOutput("model_irq_key", {5'd0, bus.irq_key}, 8'(topIdx(m_pend)));
      checkOutput("model_overrun", {7'd0, bus.overrun}, {7'd0, m_ovr});
    end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic a, input logic bb);
    btn = b; Abtn = a; Bbtn = bb;
  endtask

  task automatic pulseAck();
    bus.irq_ack = 1; step(1); bus.irq_ack = 0;
  endtask

  task automatic waitIrq(input string name, input int budget);
    int i = 0;
    while (!bus.irq && i < budget) begin step(1); i++; end
    checkOutput(name, {7'd0, bus.irq}, 8'd1);
  endtask

  task automatic waitTickAt(input string name, input int target, input int budget);
    int i = 0;
    while (!(tick && tcount == target) && i < budget) begin step(1); i++; end
    checkOutput(name, {7'd0, (tick && tcount == target)}, 8'd1);
  endtask

  int t0, t1, p0, nev;
  int evts [$];
  int exp_ev [5] = '{0, 32, 40, 48, 56};

  initial begin
    rst = 1; applyStimulus(4'hF, 1, 1);
    bus.ie = 1; bus.irq_ack = 0; bus.ovr_clr = 0;
    step(1); checking = 1; step(2); rst = 0; step(1);
    checkOutput("reset_keys", bus.keys, 8'h00);
    checkOutput("reset_irq", {7'd0, bus.irq}, 8'd0);
    checkOutput("reset_irq_key", {5'd0, bus.irq_key}, 8'd0);
    checkOutput("reset_overrun", {7'd0, bus.overrun}, 8'd0);

    // Clean press of btn[3]
    applyStimulus(4'b0111, 1, 1); step(24);
    checkOutput("press_keys", bus.keys, 8'h80);
    checkOutput("press_irq", {7'd0, bus.irq}, 8'd1);
    checkOutput("press_irq_key", {5'd0, bus.irq_key}, 8'd7);
    pulseAck();
    checkOutput("ack_irq", {7'd0, bus.irq}, 8'd0);
    applyStimulus(4'hF, 1, 1); step(24);
    checkOutput("release_keys", bus.keys, 8'h00);

    // A and B buttons map to bits 3 and 2
    applyStimulus(4'hF, 0, 0); step(24);
    checkOutput("ab_keys", bus.keys, 8'h0C);
    checkOutput("ab_key_a", {5'd0, bus.irq_key}, 8'd3);
    pulseAck();
    checkOutput("ab_key_b", {5'd0, bus.irq_key}, 8'd2);
    pulseAck();
    checkOutput("ab_irq_off", {7'd0, bus.irq}, 8'd0);
    applyStimulus(4'hF, 1, 1); step(24);

    // Bounce on btn[0]: levels last 2 ticks each
    p0 = m_press_cnt[4];
    for (int i = 0; i < 10; i++) begin
      btn[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(8);
    end
    btn[0] = 0;
    step(8);
    checkOutput("bounce_not_yet", {7'd0, bus.keys[4]}, 8'd0);
    step(16);
    checkOutput("bounce_keys4", {7'd0, bus.keys[4]}, 8'd1);
    checkOutput("bounce_irq_key", {5'd0, bus.irq_key}, 8'd4);
    checkOutput("bounce_one_event", 8'(m_press_cnt[4] - p0), 8'd1);
    checkOutput("bounce_overrun", {7'd0, bus.overrun}, 8'd0);
    pulseAck();
    btn[0] = 1; step(24);

    // Auto-repeat on btn[3], acking each event promptly
    m_rep_log.delete();
    btn[3] = 0;
    waitIrq("rep_first_irq", 60);
    t0 = tcount;
    for (int i = 0; i < 232; i++) begin
      if (bus.irq && !bus.irq_ack) begin
        bus.irq_ack = 1; evts.push_back(tcount - t0);
      end else bus.irq_ack = 0;
      step(1);
    end
    bus.irq_ack = 0;
    checkOutput("rep_count", 8'(evts.size()), 8'd5);
    for (int i = 0; i < 5 && i < evts.size(); i++)
      checkOutput("rep_tick", 8'(evts[i]), 8'(exp_ev[i]));
    checkOutput("model_rep_log_size", 8'(m_rep_log.size()), 8'd4);
    for (int i = 0; i < 4 && i < m_rep_log.size(); i++)
      checkOutput("model_rep_log", 8'(m_rep_log[i]), 8'(exp_ev[i + 1]));
    btn[3] = 1;
    nev = 0;
    for (int i = 0; i < 240; i++) begin
      if (bus.irq && !bus.irq_ack) begin bus.irq_ack = 1; nev++; end
      else bus.irq_ack = 0;
      step(1);
    end
    bus.irq_ack = 0;
    checkOutput("rep_after_release", 8'(nev), 8'd0);

    // Priority and interrupt masking
    bus.ie = 0;
    btn[0] = 0; step(24);
    btn[3] = 0; step(24);
    checkOutput("masked_irq", {7'd0, bus.irq}, 8'd0);
    pulseAck();
    bus.ie = 1; #1;
    checkOutput("unmask_irq", {7'd0, bus.irq}, 8'd1);
    checkOutput("unmask_key7", {5'd0, bus.irq_key}, 8'd7);
    step(1);
    pulseAck();
    checkOutput("prio_key4", {5'd0, bus.irq_key}, 8'd4);
    pulseAck();
    checkOutput("prio_irq_off", {7'd0, bus.irq}, 8'd0);
    applyStimulus(4'hF, 1, 1); step(24);

    // Overrun and coincident events
    btn[3] = 0;
    waitIrq("ovr_first_irq", 60);
    t0 = tcount;
    waitTickAt("ovr_wait33", t0 + 33, 200);
    checkOutput("ovr_set", {7'd0, bus.overrun}, 8'd1);
    checkOutput("ovr_pend_key", {5'd0, bus.irq_key}, 8'd7);
    bus.ovr_clr = 1; step(1); bus.ovr_clr = 0;
    checkOutput("ovr_cleared", {7'd0, bus.overrun}, 8'd0);
    waitTickAt("ovr_wait39", t0 + 39, 60);
    bus.ovr_clr = 1; step(1); bus.ovr_clr = 0;
    checkOutput("ovr_set_wins", {7'd0, bus.overrun}, 8'd1);
    bus.ovr_clr = 1; step(1); bus.ovr_clr = 0;
    waitTickAt("ovr_wait47", t0 + 47, 60);
    pulseAck();
    checkOutput("ack_evt_irq", {7'd0, bus.irq}, 8'd1);
    checkOutput("ack_evt_no_ovr", {7'd0, bus.overrun}, 8'd0);
    waitTickAt("ovr_wait57", t0 + 57, 60);
    checkOutput("ovr_again", {7'd0, bus.overrun}, 8'd1);

    // Reset during repeat with btn[3] still held
    waitTickAt("rst_align", t0 + 59, 60);
    rst = 1; step(1); rst = 0;
    checkOutput("rst_keys", bus.keys, 8'h00);
    checkOutput("rst_irq", {7'd0, bus.irq}, 8'd0);
    checkOutput("rst_irq_key", {5'd0, bus.irq_key}, 8'd0);
    checkOutput("rst_overrun", {7'd0, bus.overrun}, 8'd0);
    t1 = tcount;
    waitIrq("rst_press_irq", 40);
    checkOutput("rst_press_ticks", 8'(tcount - t1), 8'd4);
    t1 = tcount;
    pulseAck();
    waitIrq("rst_rep_irq", 200);
    checkOutput("rst_rep_ticks", 8'(tcount - t1), 8'd32);
    pulseAck();
    btn[3] = 1; step(24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
